ssd_capture_decoder: RTL and testbench

- Inverse of the hex-to-seven-segment encoder: watches a time-multiplexed, active-low 7-segment bus (segment lines plus per-digit anode enables) and reconstructs the displayed hex value.
- Per digit: waits for a stable (anode, segment) pattern, decodes it back to a nibble and stores it.
- Publishes the full NUM_DIGITS-digit word once every digit has been captured in a scan frame.
- Used as the on-chip readback and self-check path for the display driver of the pipelined processor.

---
 rtl/ssd_pkg.sv | 59 +++++
 rtl/ssd_capture_decoder_glyph_decode.sv | 18 +
 rtl/ssd_capture_decoder.sv | 92 +++++++++
 tb/tb_ssd_capture_decoder.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/ssd_pkg.sv
// Shared definitions for the seven-segment capture path: glyph constants,
// frame-control states and the glyph-to-nibble reverse lookup.
package ssd_pkg;

  typedef logic [0:6] seg_t;

  // Segment order a..g, active-low (0 = lit).
  localparam seg_t GLYPH_0   = 7'b0000001;
  localparam seg_t GLYPH_1   = 7'b1001111;
  localparam seg_t GLYPH_2   = 7'b0010010;
  localparam seg_t GLYPH_3   = 7'b0000110;
  localparam seg_t GLYPH_4   = 7'b1001100;
  localparam seg_t GLYPH_5   = 7'b0100100;
  localparam seg_t GLYPH_6   = 7'b0100000;
  localparam seg_t GLYPH_7   = 7'b0001111;
  localparam seg_t GLYPH_8   = 7'b0000000;
  localparam seg_t GLYPH_9   = 7'b0001100;
  localparam seg_t GLYPH_A   = 7'b0001000;
  localparam seg_t GLYPH_B   = 7'b1100000;
  localparam seg_t GLYPH_C   = 7'b0110001;
  localparam seg_t GLYPH_D   = 7'b1000010;
  localparam seg_t GLYPH_E   = 7'b0110000;
  localparam seg_t GLYPH_F   = 7'b0111000;
  localparam seg_t SEG_BLANK = 7'b1111111;

  typedef enum logic {COLLECT, PUBLISH} frame_state_t;

  typedef struct packed {
    logic       legal;
    logic [3:0] nib;
  } glyph_t;

  function automatic glyph_t glyph_decode(seg_t s);
    glyph_t g;
    g.legal = 1'b1;
    g.nib   = 4'h0;
    case (s)
      GLYPH_0: g.nib = 4'h0;
      GLYPH_1: g.nib = 4'h1;
      GLYPH_2: g.nib = 4'h2;
      GLYPH_3: g.nib = 4'h3;
      GLYPH_4: g.nib = 4'h4;
      GLYPH_5: g.nib = 4'h5;
      GLYPH_6: g.nib = 4'h6;
      GLYPH_7: g.nib = 4'h7;
      GLYPH_8: g.nib = 4'h8;
      GLYPH_9: g.nib = 4'h9;
      GLYPH_A: g.nib = 4'hA;
      GLYPH_B: g.nib = 4'hB;
      GLYPH_C: g.nib = 4'hC;
      GLYPH_D: g.nib = 4'hD;
      GLYPH_E: g.nib = 4'hE;
      GLYPH_F: g.nib = 4'hF;
      default: g.legal = 1'b0;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/ssd_capture_decoder_glyph_decode.sv
// Combinational reverse lookup of one active-low segment pattern.
module ssd_glyph_decode
  import ssd_pkg::*;
(
  input  logic [0:6] seg,
  output logic [3:0] nibble,
  output logic       legal
);

  glyph_t g;

  always_comb begin
    g      = glyph_decode(seg);
    nibble = g.nib;
    legal  = g.legal;
  end

endmodule

// File: rtl/ssd_capture_decoder.sv
// Reconstructs the hex word shown on a multiplexed active-low 7-segment bus:
// debounce each (anode, segment) pattern, decode it, publish full frames.
module ssd_capture_decoder
  import ssd_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [0:6]              seg_in,
  input  logic [NUM_DIGITS-1:0]   an_in,
  output logic [4*NUM_DIGITS-1:0] value_out,
  output logic                    value_valid,
  output logic [NUM_DIGITS-1:0]   captured_mask,
  output logic                    bad_pattern,
  output logic                    multi_anode
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] STAB = CW'(STABLE_CYCLES);

  logic [0:6]                  samp_seg;
  logic [NUM_DIGITS-1:0]       samp_an;
  logic [CW-1:0]               cnt, cnt_nxt;
  logic                        chg, cap_evt;
  logic [NUM_DIGITS-1:0][3:0]  slot;
  frame_state_t                state;

  logic [NUM_DIGITS-1:0] an_low, base_mask, mask_nxt;
  logic                  one_hot, multi, store;
  logic [3:0]            nib;
  logic                  legal;

  ssd_glyph_decode u_dec (
    .seg    (samp_seg),
    .nibble (nib),
    .legal  (legal)
  );

  always_comb begin
    chg     = (seg_in != samp_seg) || (an_in != samp_an);
    cnt_nxt = chg ? CW'(1) : ((cnt == STAB) ? cnt : cnt + CW'(1));
    an_low  = ~samp_an;
    one_hot = (an_low != '0) && ((an_low & (an_low - 1'b1)) == '0);
    multi   = (an_low != '0) && !one_hot;
    store   = cap_evt && one_hot && legal;
    // The publish cycle starts the next frame, so its capture lands in a clean mask.
    base_mask = (state == PUBLISH) ? '0 : captured_mask;
    mask_nxt  = base_mask | (store ? an_low : '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      samp_seg      <= '0;
      samp_an       <= '0;
      cnt           <= '0;
      cap_evt       <= 1'b0;
      slot          <= '0;
      captured_mask <= '0;
      value_out     <= '0;
      value_valid   <= 1'b0;
      bad_pattern   <= 1'b0;
      multi_anode   <= 1'b0;
      state         <= COLLECT;
    end else begin
      samp_seg <= seg_in;
      samp_an  <= an_in;
      cnt      <= cnt_nxt;
      // A change always re-arms; with STABLE_CYCLES=1 it also fires at once.
      cap_evt  <= (cnt_nxt == STAB) && (chg || cnt != STAB);

      bad_pattern <= cap_evt && one_hot && !legal;
      multi_anode <= cap_evt && multi;

      for (int i = 0; i < NUM_DIGITS; i++)
        if (store && an_low[i]) slot[i] <= nib;
      captured_mask <= mask_nxt;

      value_valid <= 1'b0;
      case (state)
        PUBLISH: begin
          value_out   <= slot;
          value_valid <= 1'b1;
        end
        default: ;
      endcase
      state <= (mask_nxt == '1) ? PUBLISH : COLLECT;
    end
  end

endmodule

// File: tb/tb_ssd_capture_decoder.sv
// Scoreboard bench: each task drives a display scan and queues the words it
// expects; a negedge monitor pops and compares on every value_valid pulse.
module tb_ssd_capture_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [0:6]  seg_in = 7'b1111111;
  logic [3:0]  an_in = 4'b1111;
  logic [15:0] value_out;
  logic        value_valid;
  logic [3:0]  captured_mask;
  logic        bad_pattern;
  logic        multi_anode;

  int checks = 0;
  int errors = 0;
  int nvalid = 0;
  int nbad   = 0;
  int nmulti = 0;
  logic [15:0] exp_q[$];

  logic [0:6] gl [16];

  ssd_capture_decoder #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .seg_in        (seg_in),
    .an_in         (an_in),
    .value_out     (value_out),
    .value_valid   (value_valid),
    .captured_mask (captured_mask),
    .bad_pattern   (bad_pattern),
    .multi_anode   (multi_anode)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bad_pattern) nbad++;
      if (multi_anode) nmulti++;
      if (value_valid) begin
        nvalid++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL word_unexpected: got %h, required no publish", value_out);
        end else begin
          logic [15:0] e;
          e = exp_q.pop_front();
          if (value_out !== e) begin
            errors++;
            $display("FAIL word: got %h, required %h", value_out, e);
          end
        end
      end
    end
  end

  task automatic hold(input logic [0:6] s, input logic [3:0] a, input int n);
    seg_in = s;
    an_in  = a;
    repeat (n) @(negedge clk);
  endtask

  task automatic cap(input int d, input int v, input int n);
    logic [3:0] a;
    a = 4'b0001 << d;
    hold(gl[v], ~a, n);
  endtask

  task automatic do_reset();
    seg_in = 7'b1111111;
    an_in  = 4'b1111;
    rst_n  = 1'b0;
    @(negedge clk);
    rst_n  = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (value_out !== 16'h0 || captured_mask !== 4'h0 || value_valid !== 1'b0 ||
        bad_pattern !== 1'b0 || multi_anode !== 1'b0) begin
      errors++;
      $display("FAIL reset: got out=%h mask=%b vv=%b bad=%b multi=%b, required all zero",
               value_out, captured_mask, value_valid, bad_pattern, multi_anode);
    end
  endtask

  task automatic test_scan();
    int v0;
    v0 = nvalid;
    exp_q.push_back(16'hF0A3);
    cap(0, 3, 6); cap(1, 10, 6); cap(2, 0, 6); cap(3, 15, 6);
    hold(7'b1111111, 4'b1111, 3);
    checks++;
    if (nvalid !== v0 + 1) begin
      errors++;
      $display("FAIL scan_pulses: got %0d, required %0d", nvalid - v0, 1);
    end
    checks++;
    if (captured_mask !== 4'b0000) begin
      errors++;
      $display("FAIL scan_mask: got %b, required 0000", captured_mask);
    end
    checks++;
    if (value_out !== 16'hF0A3) begin
      errors++;
      $display("FAIL scan_hold: got %h, required f0a3", value_out);
    end
  endtask

  task automatic test_glitch();
    int b0, m0;
    do_reset();
    b0 = nbad; m0 = nmulti;
    cap(2, 7, 3);
    cap(2, 5, 4);
    hold(7'b1111111, 4'b1111, 3);
    checks++;
    if (captured_mask !== 4'b0100) begin
      errors++;
      $display("FAIL glitch_mask: got %b, required 0100", captured_mask);
    end
    checks++;
    if (nbad !== b0 || nmulti !== m0) begin
      errors++;
      $display("FAIL glitch_flags: got bad=%0d multi=%0d, required 0 0", nbad - b0, nmulti - m0);
    end
    // Completing the frame proves slot 2 kept 5, not 7.
    exp_q.push_back(16'h2519);
    cap(0, 9, 6); cap(1, 1, 6); cap(3, 2, 6);
    hold(7'b1111111, 4'b1111, 3);
  endtask

  task automatic test_bad_pattern();
    int b0;
    do_reset();
    cap(0, 6, 6);
    b0 = nbad;
    hold(7'b1111110, 4'b1110, 4);
    hold(7'b1111111, 4'b1111, 3);
    checks++;
    if (nbad !== b0 + 1) begin
      errors++;
      $display("FAIL bad_pulse: got %0d, required 1", nbad - b0);
    end
    checks++;
    if (captured_mask !== 4'b0001) begin
      errors++;
      $display("FAIL bad_mask: got %b, required 0001", captured_mask);
    end
    exp_q.push_back(16'hED46);
    cap(1, 4, 6); cap(2, 13, 6); cap(3, 14, 6);
    hold(7'b1111111, 4'b1111, 3);
  endtask

  task automatic test_multi_anode();
    int m0, b0, v0;
    do_reset();
    m0 = nmulti; b0 = nbad; v0 = nvalid;
    hold(gl[8], 4'b1100, 4);
    hold(7'b1111111, 4'b1111, 3);
    checks++;
    if (nmulti !== m0 + 1 || captured_mask !== 4'b0000) begin
      errors++;
      $display("FAIL multi: got pulses=%0d mask=%b, required 1 0000", nmulti - m0, captured_mask);
    end
    hold(7'b1111111, 4'b1111, 6);
    checks++;
    if (nmulti !== m0 + 1 || nbad !== b0 || captured_mask !== 4'b0000 || nvalid !== v0) begin
      errors++;
      $display("FAIL blank: got multi=%0d bad=%0d mask=%b valid=%0d, required 1 0 0000 0",
               nmulti - m0, nbad - b0, captured_mask, nvalid - v0);
    end
  endtask

  task automatic test_reset_mid_frame();
    int v0;
    do_reset();
    v0 = nvalid;
    cap(0, 1, 6); cap(1, 2, 6); cap(2, 3, 6);
    do_reset();
    cap(3, 4, 6);
    hold(7'b1111111, 4'b1111, 3);
    checks++;
    if (nvalid !== v0 || value_out !== 16'h0 || captured_mask !== 4'b1000) begin
      errors++;
      $display("FAIL reset_mid: got valid=%0d out=%h mask=%b, required 0 0000 1000",
               nvalid - v0, value_out, captured_mask);
    end
  endtask

  task automatic test_back_to_back();
    int v0;
    v0 = nvalid;
    exp_q.push_back(16'h8291);
    exp_q.push_back(16'hBCDE);
    cap(0, 1, 6); cap(1, 4, 6); cap(1, 9, 6); cap(2, 2, 6); cap(3, 8, 6);
    cap(0, 14, 6); cap(1, 13, 6); cap(2, 12, 6); cap(3, 11, 6);
    hold(7'b1111111, 4'b1111, 4);
    checks++;
    if (nvalid !== v0 + 2) begin
      errors++;
      $display("FAIL b2b_pulses: got %0d, required 2", nvalid - v0);
    end
    checks++;
    if (value_out !== 16'hBCDE || captured_mask !== 4'b0000) begin
      errors++;
      $display("FAIL b2b_final: got out=%h mask=%b, required bcde 0000", value_out, captured_mask);
    end
  endtask

  initial begin
    gl = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
           7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
           7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
           7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    @(negedge clk);
    test_reset();
    test_scan();
    test_glitch();
    test_bad_pattern();
    test_multi_anode();
    test_reset_mid_frame();
    do_reset();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d words pending, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
